// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder (out_ovf only with PIPE_ADDER_OVF_EN)
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
`ifdef PIPE_ADDER_OVF_EN
        input  out_ovf,
`endif
        input  out_cout
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
`ifdef PIPE_ADDER_OVF_EN
        output out_ovf,
`endif
        output out_cout
    );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder split into SEG-bit ripple stages with valid/ready flow control
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pipelined_adder_if.slave bus
);
    localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
    localparam int NSEG     = WIDTH / SEG_SAFE;

    generate
        if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
        end
    endgenerate

    typedef struct packed {
        logic            cmsb;
        logic            cout;
        logic [SEG-1:0]  sum;
    } seg_res_t;

    // cmsb keeps the carry into the top bit of the segment for overflow detection.
    function automatic seg_res_t seg_add(input logic [SEG-1:0] a,
                                         input logic [SEG-1:0] b,
                                         input logic           cin);
        seg_res_t r;
        logic     c;
        r = '0;
        c = cin;
        for (int i = 0; i < SEG; i++) begin
            r.sum[i] = a[i] ^ b[i] ^ c;
            r.cmsb   = c;
            c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r.cout = c;
        return r;
    endfunction

    logic             v_r  [NSEG];
    logic             c_r  [NSEG];
    logic [WIDTH-1:0] a_r  [NSEG];
    logic [WIDTH-1:0] b_r  [NSEG];
    logic [WIDTH-1:0] s_r  [NSEG];

    logic [WIDTH-1:0] op_a [NSEG];
    logic [WIDTH-1:0] op_b [NSEG];
    logic [WIDTH-1:0] part [NSEG];
    logic             op_c [NSEG];
    seg_res_t         res  [NSEG];
    logic             en;

    assign en           = !v_r[NSEG-1] || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = v_r[NSEG-1];
    assign bus.out_sum   = s_r[NSEG-1];
    assign bus.out_cout  = c_r[NSEG-1];

    // Operands are shifted down as they are consumed, so every stage adds the low SEG bits;
    // finished sum segments enter at the top and slide down into place.
    always_comb begin
        op_a[0] = bus.in_a;
        op_b[0] = bus.in_b;
        op_c[0] = bus.in_cin;
        part[0] = '0;
        res[0]  = seg_add(op_a[0][SEG-1:0], op_b[0][SEG-1:0], op_c[0]);
        for (int s = 1; s < NSEG; s++) begin
            op_a[s] = a_r[s-1];
            op_b[s] = b_r[s-1];
            op_c[s] = c_r[s-1];
            part[s] = s_r[s-1];
            res[s]  = seg_add(op_a[s][SEG-1:0], op_b[s][SEG-1:0], op_c[s]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSEG; s++) begin
                v_r[s] <= 1'b0;
                c_r[s] <= 1'b0;
                a_r[s] <= '0;
                b_r[s] <= '0;
                s_r[s] <= '0;
            end
        end else if (en) begin
            v_r[0] <= bus.in_valid;
            for (int s = 1; s < NSEG; s++) begin
                v_r[s] <= v_r[s-1];
            end
            for (int s = 0; s < NSEG; s++) begin
                c_r[s] <= res[s].cout;
                a_r[s] <= op_a[s] >> SEG;
                b_r[s] <= op_b[s] >> SEG;
                s_r[s] <= (part[s] >> SEG) | (WIDTH'(res[s].sum) << (WIDTH - SEG));
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (en) begin
            ovf_r <= res[NSEG-1].cmsb ^ res[NSEG-1].cout;
        end
    end

    assign bus.out_ovf = ovf_r;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and streaming checks of pipelined_adder against a queue-based arithmetic model
module tb_pipelined_adder;
    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();
    pipelined_adder #(.WIDTH(W), .SEG(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    pipelined_adder_if #(.WIDTH(8)) bus8 ();
    pipelined_adder #(.WIDTH(8), .SEG(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_cmp = 0;
    int n_err = 0;
    logic [W+1:0] exp_q[$];

    // {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] r;
        logic       ov;
        r  = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        return {ov, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = ci;
    endtask

    // Scoreboard: results must leave in order, exactly once, matching the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stale_output: got sum %0h with no outstanding operation", bus.out_sum);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    check("stream_sum", 64'(bus.out_sum), 64'(e[W-1:0]));
                    check("stream_cout", 64'(bus.out_cout), 64'(e[W]));
`ifdef PIPE_ADDER_OVF_EN
                    check("stream_ovf", 64'(bus.out_ovf), 64'(e[W+1]));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic ci; logic [W:0] r; } vec_t;
    vec_t vecs[5];

    initial begin
        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 0; bus.out_ready = 1;
        bus8.in_valid = 0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_cin = 0; bus8.out_ready = 1;

        vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000};
        vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 33'h0_2345_678A};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
        vecs[4] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100};
        foreach (vecs[i])
            check($sformatf("model_vec%0d", i), 64'(model(vecs[i].a, vecs[i].b, vecs[i].ci) & {1'b0, {(W+1){1'b1}}}), 64'(vecs[i].r));

        // Reset state
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_sum", 64'(bus.out_sum), 0);
        check("rst_out_cout", 64'(bus.out_cout), 0);
        check("rst8_out_valid", 64'(bus8.out_valid), 0);
        #19 rst_n = 1'b1;
        step();

        // Single op: latency N edges
        put(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        for (int k = 1; k <= N; k++) begin
            step();
            bus.in_valid = 1'b0;
            check($sformatf("latency_edge%0d", k), 64'(bus.out_valid), (k == N) ? 64'd1 : 64'd0);
        end
        check("single_sum", 64'(bus.out_sum), 64'h0);
        check("single_cout", 64'(bus.out_cout), 64'h1);
`ifdef PIPE_ADDER_OVF_EN
        check("single_ovf", 64'(bus.out_ovf), 64'h0);
`endif
        step();
        check("single_done", 64'(bus.out_valid), 0);

        // Directed vectors back to back
        foreach (vecs[i]) begin
            put(vecs[i].a, vecs[i].b, vecs[i].ci);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (N + 2) step();
        check("directed_drained", 64'(exp_q.size()), 0);

        // Full-rate random stream
        for (int i = 0; i < 1000; i++) begin
            put($urandom(), $urandom(), 1'($urandom_range(0, 1)));
            check("stream_in_ready", 64'(bus.in_ready), 1);
            step();
            if (i >= N - 1) check("stream_out_valid", 64'(bus.out_valid), 1);
        end
        bus.in_valid = 1'b0;
        repeat (N + 2) step();
        check("stream_drained", 64'(exp_q.size()), 0);

        // Backpressure
        put(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); step();
        put(32'h0000_0010, 32'h0000_0020, 1'b1); step();
        put(32'hAAAA_AAAA, 32'h5555_5555, 1'b1); step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        put(32'h0000_0003, 32'h0000_0004, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(bus.out_valid), 1);
            check("bp_in_ready", 64'(bus.in_ready), 0);
            check("bp_sum", 64'(bus.out_sum), 64'h8000_0000);
`ifdef PIPE_ADDER_OVF_EN
            check("bp_ovf", 64'(bus.out_ovf), 1);
`endif
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (N + 4) step();
        check("bp_drained", 64'(exp_q.size()), 0);

        // Bubbles: 1,0,1 in -> 1,0,1 out after N edges
        put(32'h0000_0100, 32'h0000_0200, 1'b0); step();
        bus.in_valid = 1'b0; step();
        put(32'h0101_0101, 32'h0F0F_0F0F, 1'b1); step();
        bus.in_valid = 1'b0;
        step(); check("bubble_out0", 64'(bus.out_valid), 1);
        step(); check("bubble_out1", 64'(bus.out_valid), 0);
        step(); check("bubble_out2", 64'(bus.out_valid), 1);
        step(); check("bubble_out3", 64'(bus.out_valid), 0);

        // Asynchronous reset with items in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'(i + 1), 32'h1000, 1'b0);
            step();
        end
        bus.in_valid = 1'b0;
        check("pre_reset_out_valid", 64'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_out_valid", 64'(bus.out_valid), 0);
        check("async_in_ready", 64'(bus.in_ready), 1);
        check("async_out_sum", 64'(bus.out_sum), 0);
        step();
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("post_reset_idle", 64'(bus.out_valid), 0);
        end
        put(32'h0000_0001, 32'h0000_0002, 1'b0);
        for (int k = 1; k <= N; k++) begin
            step();
            bus.in_valid = 1'b0;
            check($sformatf("cold_latency_edge%0d", k), 64'(bus.out_valid), (k == N) ? 64'd1 : 64'd0);
        end
        check("cold_sum", 64'(bus.out_sum), 64'h3);
        step();

        // Single-stage instance: WIDTH = SEG = 8
        bus8.in_valid = 1'b1; bus8.in_a = 8'h80; bus8.in_b = 8'h80; bus8.in_cin = 1'b1;
        step();
        bus8.in_a = 8'h7F; bus8.in_b = 8'h01; bus8.in_cin = 1'b0;
        check("seg8_out_valid", 64'(bus8.out_valid), 1);
        check("seg8_sum", 64'(bus8.out_sum), 64'h01);
        check("seg8_cout", 64'(bus8.out_cout), 1);
`ifdef PIPE_ADDER_OVF_EN
        check("seg8_ovf", 64'(bus8.out_ovf), 1);
`endif
        step();
        bus8.in_valid = 1'b0;
        check("seg8_sum2", 64'(bus8.out_sum), 64'h80);
        check("seg8_cout2", 64'(bus8.out_cout), 0);
`ifdef PIPE_ADDER_OVF_EN
        check("seg8_ovf2", 64'(bus8.out_ovf), 1);
`endif
        step();
        check("seg8_idle", 64'(bus8.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
